// File: rtl/sbox_scan_pkg.sv
// Shared constants and state encoding for the S-box DDT scanner.
// Used by sbox_ddt_scan and sbox_ddt_bins.
package sbox_scan_pkg;

  localparam int N       = 6;
  localparam int SIZE    = 64;
  localparam int BIN_W   = 7;
  localparam int LATENCY = 4160;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_CLR  = 3'd2;
  localparam state_t ST_SCAN = 3'd3;
  localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/sbox_ddt_bins.sv
// Bank of 64 DDT bins with single-cycle clear and indexed increment.
// o_next is the value the indexed bin takes if incremented this cycle.
module sbox_ddt_bins
  import sbox_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [N-1:0]     i_idx,
  output logic [BIN_W-1:0] o_next
);

  logic [BIN_W-1:0] r_bin [SIZE];

  assign o_next = r_bin[i_idx] + 1'b1;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int k = 0; k < SIZE; k++) begin
        r_bin[k] <= '0;
      end
    end else if (i_inc) begin
      r_bin[i_idx] <= o_next;
    end
  end

endmodule

// File: rtl/sbox_ddt_scan.sv
// Differential-uniformity scanner for an external 6-bit S-box.
// Define SBOX_PERM_CHECK_EN to add the is_perm bijection output.
module sbox_ddt_scan
  import sbox_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N-1:0]     sbox_x,
  input  logic [N-1:0]     sbox_y,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] du
`ifdef SBOX_PERM_CHECK_EN
  ,
  output logic             is_perm
`endif
);

  state_t           r_state;
  logic [N-1:0]     r_i;
  logic [N-1:0]     r_x;
  logic [N-1:0]     r_a;
  logic [BIN_W-1:0] r_du;
  logic [N-1:0]     r_tab [SIZE];

  logic [N-1:0]     w_idx;
  logic [BIN_W-1:0] w_next;
  logic             w_clr;
  logic             w_inc;
  logic             w_last;

  assign w_idx  = r_tab[r_x] ^ r_tab[r_x ^ r_a];
  assign w_clr  = (r_state == ST_CLR);
  assign w_inc  = (r_state == ST_SCAN);
  assign w_last = w_inc && (r_x == '1) && (r_a == '1);

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign du     = r_du;
  assign sbox_x = (r_state == ST_LOAD) ? r_i : '0;

  sbox_ddt_bins u_bins (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .i_idx  (w_idx),
    .o_next (w_next)
  );

  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD) begin
      r_tab[r_i] <= sbox_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_x     <= '0;
      r_a     <= 6'd1;
      r_du    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_i     <= '0;
            r_x     <= '0;
            r_a     <= 6'd1;
            r_du    <= '0;
          end
        end
        ST_LOAD: begin
          r_i <= r_i + 1'b1;
          if (r_i == '1) begin
            r_state <= ST_CLR;
          end
        end
        ST_CLR: begin
          r_state <= ST_SCAN;
        end
        ST_SCAN: begin
          // r_x wraps to 0 on its own; only the state branch moves a
          r_x <= r_x + 1'b1;
          if (w_next > r_du) begin
            r_du <= w_next;
          end
          if (r_x == '1) begin
            if (r_a != '1) begin
              r_a     <= r_a + 1'b1;
              r_state <= ST_CLR;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SBOX_PERM_CHECK_EN
  logic [SIZE-1:0] r_seen;
  logic            r_perm;

  assign is_perm = r_perm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen <= '0;
      r_perm <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_seen <= '0;
      r_perm <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_seen[sbox_y] <= 1'b1;
    end else if (w_last) begin
      r_perm <= &r_seen;
    end
  end
`endif

endmodule

// File: tb/tb_sbox_ddt_scan.sv
// Self-checking bench for sbox_ddt_scan: fixed S-box table, random S-boxes
// against a DDT model, and reset / start-while-busy corner sequences.
module tb_sbox_ddt_scan;
  import sbox_scan_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] sbox_x;
  logic [5:0] sbox_y;
  logic       busy;
  logic       done;
  logic [6:0] du;
`ifdef SBOX_PERM_CHECK_EN
  logic       is_perm;
`endif

  logic [5:0] sb [64];
  int nerr;
  int nchk;

  assign sbox_y = sb[sbox_x];

  sbox_ddt_scan dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sbox_x  (sbox_x),
    .sbox_y  (sbox_y),
    .busy    (busy),
    .done    (done),
    .du      (du)
`ifdef SBOX_PERM_CHECK_EN
    ,
    .is_perm (is_perm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] gf_mul(input logic [5:0] a,
                                        input logic [5:0] b);
    logic [5:0] p;
    logic [5:0] aa;
    logic       c;
    p  = '0;
    aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) p = p ^ aa;
      c  = aa[5];
      aa = {aa[4:0], 1'b0};
      if (c) aa = aa ^ 6'h03;
    end
    return p;
  endfunction

  function automatic logic [5:0] gf_pow(input logic [5:0] x, input int e);
    logic [5:0] r;
    r = 6'd1;
    for (int i = 0; i < e; i++) r = gf_mul(r, x);
    return r;
  endfunction

  // reference: DDT max over nonzero input differences
  function automatic int model_du();
    int cnt [64];
    int m;
    m = 0;
    for (int a = 1; a < 64; a++) begin
      for (int d = 0; d < 64; d++) cnt[d] = 0;
      for (int x = 0; x < 64; x++) cnt[sb[x] ^ sb[x ^ a]]++;
      for (int d = 0; d < 64; d++) if (cnt[d] > m) m = cnt[d];
    end
    return m;
  endfunction

  function automatic int model_perm();
    bit seen [64];
    for (int v = 0; v < 64; v++) seen[v] = 0;
    for (int x = 0; x < 64; x++) seen[sb[x]] = 1;
    for (int v = 0; v < 64; v++) if (!seen[v]) return 0;
    return 1;
  endfunction

  task automatic fill(input int kind);
    int j;
    logic [5:0] t;
    for (int x = 0; x < 64; x++) begin
      case (kind)
        0: sb[x] = 6'(x);
        1: sb[x] = 6'd0;
        2: sb[x] = gf_pow(6'(x), 3);
        3: sb[x] = gf_pow(6'(x), 62);
        4: sb[x] = 6'($urandom_range(0, 63));
        default: sb[x] = 6'(x);
      endcase
    end
    if (kind == 5) begin
      for (int x = 63; x > 0; x--) begin
        j = $urandom_range(0, x);
        t = sb[x];
        sb[x] = sb[j];
        sb[j] = t;
      end
    end
  endtask

  // start one scan and check latency, LOAD sequencing, results and hold
  task automatic run(input string name, input int edu, input int eperm);
    int lat;
    int bad;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bad = 0;
    while (!done && lat < 6000) begin
      if (!busy) bad++;
      if (lat <= 64 && sbox_x != 6'(lat - 1)) bad++;
      if (lat > 64 && sbox_x != 6'd0) bad++;
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, LATENCY);
    check({name, "_seq"}, bad, 0);
    check({name, "_du"}, int'(du), edu);
`ifdef SBOX_PERM_CHECK_EN
    check({name, "_perm"}, int'(is_perm), eperm);
`endif
    @(negedge clk);
    check({name, "_done_pulse"}, int'({done, busy}), 0);
    repeat (3) @(negedge clk);
    check({name, "_du_hold"}, int'(du), edu);
  endtask

  typedef struct {
    string name;
    int    kind;
    int    du;
    int    perm;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int cnt;
    int mdu;
    int mperm;
    nerr  = 0;
    nchk  = 0;
    rst   = 1'b1;
    start = 1'b0;
    fill(0);

    vecs[0] = '{"identity", 0, 64, 1};
    vecs[1] = '{"const0",   1, 64, 0};
    vecs[2] = '{"cube",     2, 2,  0};
    vecs[3] = '{"inverse",  3, 4,  1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_state", int'({busy, done, du, sbox_x}), 0);

    for (int v = 0; v < 4; v++) begin
      fill(vecs[v].kind);
      check({vecs[v].name, "_model"}, model_du(), vecs[v].du);
      run(vecs[v].name, vecs[v].du, vecs[v].perm);
    end

    for (int r = 0; r < 4; r++) begin
      fill((r == 3) ? 5 : 4);
      run($sformatf("rand%0d", r), model_du(), model_perm());
    end

    // reset mid-scan
    fill(2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1999) @(negedge clk);
    check("mid_scan_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_scan", int'({busy, done, du, sbox_x}), 0);
    fill(3);
    run("after_rst", model_du(), model_perm());

    // reset mid-load
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_load", int'({busy, done, du, sbox_x}), 0);

    // start while busy
    fill(4);
    mdu = model_du();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int c = 1; c < 4400; c++) begin
      if (done) begin
        cnt++;
        check("busy_done_cycle", c, LATENCY);
        check("busy_du", int'(du), mdu);
      end
      start = (c < 4100) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_done_count", cnt, 1);

    // start and rst together
    @(negedge clk);
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check("rst_start_busy", int'(busy), 0);
    @(negedge clk);
    check("rst_start_idle", int'({busy, done}), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
